slot_credit_controller: RTL
===========================

# slot_credit_controller

Player-side controller for the slot reel machine. It tracks coin credits, deducts the bet when play is pressed, and drives the machine's lever input through a full pull sequence. It captures the reel values and win code at the end of the pull, computes the prize, and dispenses winnings one coin at a time to the hopper over a valid/ready handshake. It sits between the front-panel inputs (coin, play button) and the reel machine's `data_in` / reel / win outputs.

## Interface
Parameters:
- `BET`, default 1: credits deducted per play.
- `PULL_CYCLES`, default 5: cycles the lever is held high per play. Must be ≥5.
- `JACKPOT_PAY`, default 20: coins paid when `win_code` equals 5.
- `PAIR_PAY`, default 2: coins paid when exactly two reels match.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `coin_in`  in  1  one-cycle pulse; adds 1 credit
- `play`  in  1  one-cycle pulse; request a spin
- `reel0`, `reel1`, `reel2`  in  3 each  reel values from the machine
- `win_code`  in  3  machine result; 5 means jackpot
- `lever`  out  1  drives the machine's `data_in`
- `credits`  out  8  current credit balance
- `busy`  out  1  high in any state other than IDLE
- `no_credit`  out  1  one-cycle pulse; play was refused
- `coin_reject`  out  1  one-cycle pulse; coin was refused
- `result_valid`  out  1  one-cycle pulse; `last_win` has been updated
- `last_win`  out  8  prize of the most recent spin
- `payout_valid`  out  1  a coin is offered to the hopper
- `payout_ready`  in  1  hopper accepts the offered coin

## Operation
States: IDLE, PULL, EVAL, PAY, RELEASE.

- **IDLE**
  - On `play` with `credits ≥ BET` (registered value): go to PULL, subtract BET.
  - On `play` with `credits < BET`: pulse `no_credit`, stay in IDLE.
  - `play` outside IDLE is ignored.
- **PULL**
  - `lever` = 1 for exactly PULL_CYCLES cycles. A pull counter counts 0..PULL_CYCLES−1.
  - On the final PULL cycle, latch `reel0..2` and `win_code` into result registers. Then go to EVAL.
- **EVAL**
  - `lever` = 0. The machine returns to its idle state.
  - Prize: `JACKPOT_PAY` if latched `win_code` == 5; else `PAIR_PAY` if exactly two latched reels are equal; else 0.
  - Load `last_win` and the pay counter with the prize, and pulse `result_valid`.
  - Next state: PAY if prize > 0, otherwise RELEASE.
- **PAY**
  - `payout_valid` = 1.
  - Each cycle with `payout_valid && payout_ready` decrements the pay counter.
  - When the final coin is accepted, go to RELEASE. `payout_valid` drops in the next cycle.
- **RELEASE**
  - One cycle with `lever` = 0, which guarantees a low gap before the next pull. Then go to IDLE.

Credit rules:
- `coin_in` is accepted in every state.
- `credits` saturates at 255. A coin arriving at 255 is dropped and `coin_reject` pulses.
- If `coin_in` and an accepted `play` occur in the same cycle, the result is `credits + 1 − BET`, still saturating at 255.
- Winnings go to the hopper, never to `credits`.
- All credit arithmetic is 9-bit internally, clamped to 8 bits.

## Timing
- Reset values: `lever` 0, `credits` 0, `busy` 0, `no_credit` 0, `coin_reject` 0, `result_valid` 0, `last_win` 0, `payout_valid` 0. State is IDLE and the pay counter is 0.
- Reset mid-spin aborts the spin: `lever` drops on the next edge, credits are cleared, and no refund is made.
- With `play` accepted in cycle t:
  - `credits` is updated and `lever` is high in cycles t+1 .. t+PULL_CYCLES.
  - Result is latched at the end of cycle t+PULL_CYCLES.
  - EVAL is cycle t+PULL_CYCLES+1, with the `result_valid` pulse and `last_win` updated.
  - `payout_valid` is first high in t+PULL_CYCLES+2.
- `payout_valid` never drops while coins remain, regardless of `payout_ready`.
- Zero-prize spin: busy for PULL_CYCLES+2 cycles, and the next `play` is accepted at t+PULL_CYCLES+3.

## Structure
- Shared package `slot_pkg`:
  - state enum
  - `WIN_JACKPOT` = 3'd5
  - `REEL_W` = 3
  - `CREDIT_W` = 8
- Sub-module `slot_prize_eval`: combinational; inputs are the latched reels and win code plus the pay parameters; output is the 8-bit prize.
- All other logic lives in the top module.

## Test plan
- Reset, 3 `coin_in` pulses, then `play` → `credits` 3→2 one cycle after `play`; `lever` high exactly 5 cycles; `busy` covers the whole spin.
- Machine model returns `win_code` = 5 → `last_win` = 20; with `payout_ready` toggled 1/0 every cycle, exactly 20 handshakes occur and `payout_valid` is held between them.
- Reels 3,3,6 with `win_code` 0 → prize 2. Reels 1,4,7 → prize 0, no `payout_valid`, back to IDLE at t+8.
- `play` with `credits` = 0 → `no_credit` pulse, `lever` stays 0. 256 coins → `credits` = 255 and one `coin_reject` pulse.
- `coin_in` and `play` in the same cycle at `credits` = 1 → `credits` = 1. `play` pressed during PULL is ignored.
- `reset` asserted on the 3rd PULL cycle → next cycle `lever` 0, `credits` 0, IDLE, no `result_valid`.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot reel controller.
package slot_pkg;

    localparam int REEL_W   = 3;
    localparam int CREDIT_W = 8;

    localparam logic [2:0] WIN_JACKPOT = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        PULL,
        EVAL,
        PAY,
        RELEASE
    } state_t;

endpackage

// File: rtl/slot_prize_eval.sv
// Combinational prize lookup from the latched reel values and win code.
module slot_prize_eval
    import slot_pkg::*;
#(
    parameter int JACKPOT_PAY = 20,
    parameter int PAIR_PAY    = 2
) (
    input  logic [REEL_W-1:0]   reel0,
    input  logic [REEL_W-1:0]   reel1,
    input  logic [REEL_W-1:0]   reel2,
    input  logic [2:0]          win_code,
    output logic [CREDIT_W-1:0] prize
);

    logic [1:0] match_cnt;

    // Exactly one equal pair means two reels match; three equal pairs is a triple.
    always_comb begin
        match_cnt = {1'b0, reel0 == reel1} + {1'b0, reel1 == reel2} + {1'b0, reel0 == reel2};
        prize     = '0;
        if (win_code == WIN_JACKPOT) begin
            prize = CREDIT_W'(JACKPOT_PAY);
        end else if (match_cnt == 2'd1) begin
            prize = CREDIT_W'(PAIR_PAY);
        end
    end

endmodule

// File: rtl/slot_credit_controller.sv
// Player-side slot controller: credit bookkeeping, lever pull sequencing,
// result capture and coin-by-coin payout to the hopper.
module slot_credit_controller
    import slot_pkg::*;
#(
    parameter int BET         = 1,
    parameter int PULL_CYCLES = 5,
    parameter int JACKPOT_PAY = 20,
    parameter int PAIR_PAY    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_in,
    input  logic                play,
    input  logic [REEL_W-1:0]   reel0,
    input  logic [REEL_W-1:0]   reel1,
    input  logic [REEL_W-1:0]   reel2,
    input  logic [2:0]          win_code,
    output logic                lever,
    output logic [CREDIT_W-1:0] credits,
    output logic                busy,
    output logic                no_credit,
    output logic                coin_reject,
    output logic                result_valid,
    output logic [CREDIT_W-1:0] last_win,
    output logic                payout_valid,
    input  logic                payout_ready
);

    localparam int                  PCNT_W     = $clog2(PULL_CYCLES);
    localparam logic [PCNT_W-1:0]   PULL_LAST  = PCNT_W'(PULL_CYCLES - 1);
    localparam logic [CREDIT_W:0]   BET_EXT    = (CREDIT_W + 1)'(BET);
    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    state_t                state_q, state_d;
    logic [PCNT_W-1:0]     pull_cnt_q, pull_cnt_d;
    logic [CREDIT_W-1:0]   pay_cnt_q, pay_cnt_d;
    logic [CREDIT_W-1:0]   credits_q, credits_d;
    logic [CREDIT_W-1:0]   last_win_q, last_win_d;
    logic [REEL_W-1:0]     reel0_q, reel0_d;
    logic [REEL_W-1:0]     reel1_q, reel1_d;
    logic [REEL_W-1:0]     reel2_q, reel2_d;
    logic [2:0]            win_q, win_d;
    logic                  no_credit_q, no_credit_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  play_accept;
    logic [CREDIT_W:0]     credit_sum;
    logic [CREDIT_W-1:0]   prize;

    slot_prize_eval #(
        .JACKPOT_PAY (JACKPOT_PAY),
        .PAIR_PAY    (PAIR_PAY)
    ) u_prize_eval (
        .reel0    (reel0_q),
        .reel1    (reel1_q),
        .reel2    (reel2_q),
        .win_code (win_q),
        .prize    (prize)
    );

    always_comb begin
        state_d       = state_q;
        pull_cnt_d    = pull_cnt_q;
        pay_cnt_d     = pay_cnt_q;
        last_win_d    = last_win_q;
        reel0_d       = reel0_q;
        reel1_d       = reel1_q;
        reel2_d       = reel2_q;
        win_d         = win_q;
        no_credit_d   = 1'b0;
        coin_reject_d = 1'b0;
        play_accept   = 1'b0;
        credits_d     = credits_q;
        credit_sum    = '0;

        case (state_q)
            IDLE: begin
                if (play) begin
                    if ({1'b0, credits_q} >= BET_EXT) begin
                        play_accept = 1'b1;
                        pull_cnt_d  = '0;
                        state_d     = PULL;
                    end else begin
                        no_credit_d = 1'b1;
                    end
                end
            end
            PULL: begin
                if (pull_cnt_q == PULL_LAST) begin
                    reel0_d = reel0;
                    reel1_d = reel1;
                    reel2_d = reel2;
                    win_d   = win_code;
                    state_d = EVAL;
                end else begin
                    pull_cnt_d = pull_cnt_q + PCNT_W'(1);
                end
            end
            EVAL: begin
                last_win_d = prize;
                pay_cnt_d  = prize;
                state_d    = (prize != '0) ? PAY : RELEASE;
            end
            PAY: begin
                if (payout_ready) begin
                    pay_cnt_d = pay_cnt_q - CREDIT_W'(1);
                    if (pay_cnt_q == CREDIT_W'(1)) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A play is only accepted when credits cover the bet, so the sum cannot underflow.
        credit_sum = {1'b0, credits_q} + {{CREDIT_W{1'b0}}, coin_in}
                   - (play_accept ? BET_EXT : '0);
        if (credit_sum > CREDIT_MAX) begin
            credits_d     = CREDIT_MAX[CREDIT_W-1:0];
            coin_reject_d = 1'b1;
        end else begin
            credits_d = credit_sum[CREDIT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pull_cnt_q    <= '0;
            pay_cnt_q     <= '0;
            credits_q     <= '0;
            last_win_q    <= '0;
            reel0_q       <= '0;
            reel1_q       <= '0;
            reel2_q       <= '0;
            win_q         <= '0;
            no_credit_q   <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pull_cnt_q    <= pull_cnt_d;
            pay_cnt_q     <= pay_cnt_d;
            credits_q     <= credits_d;
            last_win_q    <= last_win_d;
            reel0_q       <= reel0_d;
            reel1_q       <= reel1_d;
            reel2_q       <= reel2_d;
            win_q         <= win_d;
            no_credit_q   <= no_credit_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    // The new prize is shown during EVAL itself, alongside the result_valid pulse.
    assign lever        = (state_q == PULL);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == EVAL);
    assign payout_valid = (state_q == PAY);
    assign last_win     = result_valid ? prize : last_win_q;
    assign credits      = credits_q;
    assign no_credit    = no_credit_q;
    assign coin_reject  = coin_reject_q;

endmodule
